alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Sequencing controller in front of the 8-bit ALU (ports a, b, funct, result; internal hi/lo product register).
- Accepts one operation per valid/ready request and drives the ALU operands and funct.
- Runs the multi-step funct sequence that MUL/DIV need (compute, read high byte, read low byte).
- Returns a 16-bit result through a valid/ready response channel. It is the only driver of the ALU.

Parameters:
PARK_FUNCT, 3'b110, funct driven while idle; must be a read-only code (110 or 111), never 100/101.
DIV0_DATA, 16'hFFFF, rsp_data returned for divide-by-zero.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request valid
req_ready  output  1  controller can accept a request
req_op  input  3  000 AND, 001 NOR, 010 ADD, 011 SUB, 100 MUL, 101 DIV; 110/111 illegal
req_a  input  8  operand a
req_b  input  8  operand b
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts response
rsp_data  output  16  result
rsp_err  output  1  divide-by-zero or illegal op
busy  output  1  high in any state except IDLE
alu_a  output  8  to ALU a
alu_b  output  8  to ALU b
alu_funct  output  3  to ALU funct
alu_result  input  8  from ALU result

Behaviour:
- The ALU evaluates only when funct changes. All alu_* outputs are registered. Every step changes alu_funct relative to the previous cycle.
- States: IDLE, EXEC, RDHI, RDLO, RESP.
- Reset (async, any state, including mid-MUL/DIV) forces:
  - state=IDLE; req_ready=1
  - rsp_valid=0, rsp_err=0, rsp_data=0, busy=0
  - alu_a=0, alu_b=0, alu_funct=PARK_FUNCT
  - any in-flight result is discarded.
- IDLE:
  - req_ready=1, alu_funct=PARK_FUNCT.
  - On req_valid&&req_ready, register alu_a=req_a, alu_b=req_b and the op.
  - Illegal op, or DIV with req_b==0: go directly to RESP with rsp_err=1; rsp_data=DIV0_DATA for div0, 0 for illegal. The ALU is never stepped.
  - Otherwise go to EXEC.
- EXEC: alu_funct=op.
  - AND/NOR/ADD/SUB: on exit, capture rsp_data={8'h00, alu_result} and go to RESP.
  - MUL/DIV: go to RDHI; nothing is captured.
- RDHI: alu_funct=110; on exit capture rsp_data[15:8]=alu_result; go to RDLO.
- RDLO: alu_funct=111; on exit capture rsp_data[7:0]=alu_result; go to RESP.
- RESP:
  - alu_funct=PARK_FUNCT; rsp_valid=1.
  - rsp_data and rsp_err are held stable until rsp_valid&&rsp_ready; then go to IDLE and clear rsp_valid.
  - req_ready=0 throughout.
- Latency from the accept edge to rsp_valid high: 2 cycles for logic/arith, 4 for MUL/DIV, 1 for error cases.
- Throughput is one operation in flight; no overlap. A new request is accepted only in IDLE, one cycle after the response handshake.
- Results:
  - MUL: rsp_data = a*b, full 16 bits.
  - DIV: rsp_data = {a%b, a/b}.
  - ADD/SUB: 8-bit wraparound; no carry/borrow; upper byte 0.
- Back-to-back identical ops recompute correctly because funct always passes through PARK_FUNCT between them.
- rsp_err is cleared on accept of the next request.

Decomposition:
- Shared package alu_pkg holds:
  - funct localparams FUNCT_AND..FUNCT_RDLO (000..111)
  - the state enum typedef (IDLE, EXEC, RDHI, RDLO, RESP)
  - a helper function is_legal_op.
- No sub-module. The level above instantiates alu_seq_ctrl next to the existing ALU and wires the alu_* ports.

Test Plan:
- ADD a=200, b=100 -> rsp_data=16'h002C, rsp_err=0, rsp_valid 2 cycles after accept; alu_funct sequence 110,010,110.
- MUL a=200, b=100 -> rsp_data=16'h4E20 after 4 cycles; funct sequence 110,100,110,111,110.
- DIV a=200, b=7 -> rsp_data=16'h041C. DIV a=5, b=0 -> rsp_err=1, rsp_data=16'hFFFF, funct stays 110 throughout.
- Two back-to-back SUB a=5, b=7 with rsp_ready=1 -> both return 16'h00FE; second accepted exactly one cycle after the first response handshake.
- rsp_ready held low 3 cycles during a NOR a=8'h0F, b=8'h30 response -> rsp_data=16'h00C0 held stable, req_ready=0; then illegal op 110 -> rsp_err=1, rsp_data=0.
- reset asserted during RDHI of a MUL -> immediate IDLE, all outputs at reset values, alu_funct=110. A following ADD 1+1 returns 16'h0002.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, controller state encoding and op legality helper shared with the ALU.
package alu_pkg;
  localparam logic [2:0] FUNCT_AND  = 3'b000;
  localparam logic [2:0] FUNCT_NOR  = 3'b001;
  localparam logic [2:0] FUNCT_ADD  = 3'b010;
  localparam logic [2:0] FUNCT_SUB  = 3'b011;
  localparam logic [2:0] FUNCT_MUL  = 3'b100;
  localparam logic [2:0] FUNCT_DIV  = 3'b101;
  localparam logic [2:0] FUNCT_RDHI = 3'b110;
  localparam logic [2:0] FUNCT_RDLO = 3'b111;
  typedef enum logic [2:0] {IDLE, EXEC, RDHI, RDLO, RESP} state_t;
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= FUNCT_DIV;
  endfunction
endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: accepts one ALU op per request, steps the ALU funct sequence and returns a 16-bit result.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter logic [2:0]  PARK_FUNCT = FUNCT_RDHI,
  parameter logic [15:0] DIV0_DATA  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_funct,
  input  logic [7:0]  alu_result
);
  state_t     state;
  logic [2:0] op;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= PARK_FUNCT;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 16'h0000;
      busy      <= 1'b0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_funct <= PARK_FUNCT;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          alu_a     <= req_a;
          alu_b     <= req_b;
          op        <= req_op;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          rsp_err   <= 1'b0;
          // error cases never step the ALU, so funct stays parked
          if (!is_legal_op(req_op) || (req_op == FUNCT_DIV && req_b == 8'h00)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= is_legal_op(req_op) ? DIV0_DATA : 16'h0000;
          end else begin
            state     <= EXEC;
            alu_funct <= req_op;
          end
        end
        EXEC: if (op == FUNCT_MUL || op == FUNCT_DIV) begin
          state     <= RDHI;
          alu_funct <= FUNCT_RDHI;
        end else begin
          state     <= RESP;
          rsp_data  <= {8'h00, alu_result};
          rsp_valid <= 1'b1;
          alu_funct <= PARK_FUNCT;
        end
        RDHI: begin
          state          <= RDLO;
          rsp_data[15:8] <= alu_result;
          alu_funct      <= FUNCT_RDLO;
        end
        RDLO: begin
          state         <= RESP;
          rsp_data[7:0] <= alu_result;
          rsp_valid     <= 1'b1;
          alu_funct     <= PARK_FUNCT;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vectors against a behavioural ALU that evaluates on funct changes.
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [7:0]  req_a = 8'h00;
  logic [7:0]  req_b = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  alu_a, alu_b, alu_result = 8'h00;
  logic [2:0]  alu_funct;
  logic [7:0]  hi = 8'h00, lo = 8'h00;
  logic [2:0]  prev_funct = 3'b110;
  int          n_vec = 0, n_err = 0;

  alu_seq_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_funct(alu_funct), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // ALU only reacts when funct differs from the last value it saw
  always @(negedge clk) begin
    if (alu_funct != prev_funct) begin
      prev_funct = alu_funct;
      case (alu_funct)
        3'b000: alu_result = alu_a & alu_b;
        3'b001: alu_result = ~(alu_a | alu_b);
        3'b010: alu_result = alu_a + alu_b;
        3'b011: alu_result = alu_a - alu_b;
        3'b100: begin {hi, lo} = alu_a * alu_b; alu_result = lo; end
        3'b101: if (alu_b != 0) begin hi = alu_a % alu_b; lo = alu_a / alu_b; alu_result = lo; end
        3'b110: alu_result = hi;
        default: alu_result = lo;
      endcase
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [14:0] seq, output int lat);
    @(negedge clk);
    seq = {12'h000, alu_funct};
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("accept_busy", {15'h0, busy}, 16'h1);
    seq = {seq[11:0], alu_funct};
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      seq = {seq[11:0], alu_funct};
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_data, input logic exp_err, input int exp_lat,
                        input logic [14:0] exp_seq, input int hold);
    logic [14:0] seq;
    int lat;
    issue(op, a, b, seq, lat);
    check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check({tag, "_seq"}, {1'b0, seq}, {1'b0, exp_seq});
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_err"}, {15'h0, rsp_err}, {15'h0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_data"}, rsp_data, exp_data);
      check({tag, "_hold_valid"}, {15'h0, rsp_valid}, 16'h1);
      check({tag, "_hold_rdy"}, {15'h0, req_ready}, 16'h0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check({tag, "_done"}, {13'h0, rsp_valid, req_ready, busy}, 16'b010);
  endtask

  initial begin
    logic [14:0] seq;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {12'h0, req_ready, rsp_valid, rsp_err, busy}, 16'b1000);
    check("rst_data", rsp_data, 16'h0000);
    check("rst_alu", {alu_a, alu_b}, 16'h0000);
    check("rst_funct", {13'h0, alu_funct}, 16'h6);
    @(negedge clk); reset = 1'b0;
    run_op("add",   3'b010, 8'd200, 8'd100, 16'h002C, 1'b0, 2, 15'b110_010_110, 0);
    run_op("mul",   3'b100, 8'd200, 8'd100, 16'h4E20, 1'b0, 4, 15'b110_100_110_111_110, 0);
    run_op("div",   3'b101, 8'd200, 8'd7,   16'h041C, 1'b0, 4, 15'b110_101_110_111_110, 0);
    run_op("div0",  3'b101, 8'd5,   8'd0,   16'hFFFF, 1'b1, 1, 15'b110_110, 0);
    run_op("sub1",  3'b011, 8'd5,   8'd7,   16'h00FE, 1'b0, 2, 15'b110_011_110, 0);
    run_op("sub2",  3'b011, 8'd5,   8'd7,   16'h00FE, 1'b0, 2, 15'b110_011_110, 0);
    run_op("nor",   3'b001, 8'h0F,  8'h30,  16'h00C0, 1'b0, 2, 15'b110_001_110, 3);
    run_op("ill",   3'b110, 8'h12,  8'h34,  16'h0000, 1'b1, 1, 15'b110_110, 0);
    run_op("and",   3'b000, 8'hF0,  8'h3C,  16'h0030, 1'b0, 2, 15'b110_000_110, 0);
    // abort a MUL while it is reading the high byte
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b100; req_a = 8'd200; req_b = 8'd100;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rdhi_funct", {13'h0, alu_funct}, 16'h6);
    reset = 1'b1; #1;
    check("arst_flags", {12'h0, req_ready, rsp_valid, rsp_err, busy}, 16'b1000);
    check("arst_data", rsp_data, 16'h0000);
    check("arst_alu", {alu_a, alu_b}, 16'h0000);
    check("arst_funct", {13'h0, alu_funct}, 16'h6);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {14'h0, rsp_valid, busy}, 16'h0);
    run_op("add11", 3'b010, 8'd1,   8'd1,   16'h0002, 1'b0, 2, 15'b110_010_110, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
